// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Drives one shared decoder (x -> z), one-hot digit enables with dead time, and frame-synchronous data commit.
module seg7_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int DIGIT_CYCLES = 1000,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic [N_DIGITS-1:0]     blank_in,
  output logic                    load_ack,
  output logic [3:0]              x,
  input  logic [6:0]              z,
  output logic [6:0]              seg,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam int IDX_W = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(DIGIT_CYCLES - GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_GAP = 2'd1,
    S_ON  = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic                   frame_end;

  logic                   pend, pend_nxt, commit;
  logic [4*N_DIGITS-1:0]  pend_data, act_data, act_data_nxt;
  logic [N_DIGITS-1:0]    pend_blank, act_blank, act_blank_nxt;

  logic [N_DIGITS-1:0]    an_nxt;
  logic [3:0]             x_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_OFF;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Dropping en wins over any slot/frame transition, so an aborted frame never reports done.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    frame_end = 1'b0;
    case (state)
      S_OFF: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (en) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (!en) begin
          state_nxt = S_OFF;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else if (cnt == GAP_LAST) begin
          state_nxt = S_ON;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_ON: begin
        if (!en) begin
          state_nxt = S_OFF;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else if (cnt == ON_LAST) begin
          state_nxt = S_GAP;
          cnt_nxt   = '0;
          if (idx == IDX_LAST) begin
            idx_nxt   = '0;
            frame_end = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_OFF;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // A load in the commit cycle stays pending; the older pending value is the one committed.
  always_comb begin
    commit        = pend && ((state == S_OFF) || frame_end);
    act_data_nxt  = commit ? pend_data  : act_data;
    act_blank_nxt = commit ? pend_blank : act_blank;
    if (load)        pend_nxt = 1'b1;
    else if (commit) pend_nxt = 1'b0;
    else             pend_nxt = pend;
  end

  // Outputs look ahead at the next state so x and an change on the same edge as the transition.
  always_comb begin
    an_nxt = '0;
    x_nxt  = '0;
    if (state_nxt != S_OFF) x_nxt = act_data_nxt[{idx_nxt, 2'b00} +: 4];
    if (state_nxt == S_ON && !act_blank_nxt[idx_nxt]) an_nxt[idx_nxt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= 1'b0;
      act_data   <= '0;
      act_blank  <= '0;
      an         <= '0;
      x          <= '0;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pend       <= pend_nxt;
      act_data   <= act_data_nxt;
      act_blank  <= act_blank_nxt;
      an         <= an_nxt;
      x          <= x_nxt;
      load_ack   <= commit;
      frame_done <= frame_end;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      pend_data  <= data_in;
      pend_blank <= blank_in;
    end
  end

  assign seg = (an != '0) ? z : 7'd0;

endmodule
